// File: rtl/layer_pkg.sv
// layer_pkg: shared state encodings for the layer arbiter
package layer_pkg;
  typedef enum logic {eEMPTY, eFULL} buf_state_e;
  typedef enum logic {eIDLE, eLOCKED} lock_state_e;
endpackage

// File: rtl/rr_priority_select.sv
// rr_priority_select: first set request at or after ptr, wrapping modulo N_REQ
module rr_priority_select #(
  parameter int N_REQ = 4,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  sel,
  output logic             any
);
  logic [ID_W-1:0] k;
  always_comb begin
    sel = '0;
    any = 1'b0;
    k   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = ID_W'((int'(ptr) + i) % N_REQ);
      if (req[k]) begin
        sel = k;
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rr_layer_arbiter.sv
// rr_layer_arbiter: round-robin packet-locked arbiter feeding a single-entry output register
module rr_layer_arbiter
  import layer_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [N_REQ-1:0]       valid_i,
  input  logic [N_REQ-1:0]       last_i,
  input  logic [N_REQ*WIDTH-1:0] data_i,
  output logic [N_REQ-1:0]       ready_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [WIDTH-1:0]       data_r_o,
  output logic [ID_W-1:0]        id_r_o,
  output logic                   last_r_o
);
  buf_state_e      buf_q, buf_d;
  lock_state_e     lock_q, lock_d;
  logic [ID_W-1:0] owner_q, owner_d, rr_ptr, rr_ptr_d, pick, sel;
  logic            any, space, grant_en, accept, last_sel;
  rr_priority_select #(.N_REQ(N_REQ)) u_sel (
    .req(valid_i),
    .ptr(rr_ptr),
    .sel(pick),
    .any(any)
  );
  always_comb begin
    space    = (buf_q == eEMPTY) || ready_i;
    sel      = (lock_q == eLOCKED) ? owner_q : pick;
    grant_en = (lock_q == eLOCKED) || any;
    last_sel = last_i[sel];
    accept   = space && grant_en && valid_i[sel];
    ready_o  = (reset_i && space && grant_en) ? N_REQ'(1) << sel : '0;
    valid_o  = buf_q == eFULL;
    buf_d    = accept ? eFULL : (ready_i ? eEMPTY : buf_q);
    lock_d   = accept ? (last_sel ? eIDLE : eLOCKED) : lock_q;
    owner_d  = (accept && !last_sel) ? sel : owner_q;
    rr_ptr_d = (accept && last_sel) ? ((sel == ID_W'(N_REQ - 1)) ? '0 : sel + ID_W'(1)) : rr_ptr;
  end
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      buf_q    <= eEMPTY;
      lock_q   <= eIDLE;
      owner_q  <= '0;
      rr_ptr   <= '0;
      data_r_o <= '0;
      id_r_o   <= '0;
      last_r_o <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      lock_q  <= lock_d;
      owner_q <= owner_d;
      rr_ptr  <= rr_ptr_d;
      if (accept) begin
        data_r_o <= data_i[sel*WIDTH +: WIDTH];
        id_r_o   <= sel;
        last_r_o <= last_sel;
      end
    end
  end
endmodule

// File: tb/tb_rr_layer_arbiter.sv
// tb_rr_layer_arbiter: randomized + directed scoreboard bench for rr_layer_arbiter
module tb_rr_layer_arbiter;
  localparam int N = 4;
  localparam int W = 16;
  logic           clk_i = 1'b0;
  logic           reset_i = 1'b1;
  logic [N-1:0]   valid_i = '0, last_i = '0, ready_o;
  logic [N*W-1:0] data_i = '0;
  logic           valid_o, ready_i = 1'b0, last_r_o;
  logic [W-1:0]   data_r_o;
  logic [1:0]     id_r_o;
  int total = 0, bad = 0;
  int owner = -1, ptr = 0;
  bit full = 0;
  logic [W+2:0] sb[$];
  rr_layer_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .last_i(last_i),
    .data_i(data_i), .ready_o(ready_o), .valid_o(valid_o), .ready_i(ready_i),
    .data_r_o(data_r_o), .id_r_o(id_r_o), .last_r_o(last_r_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask
  // one cycle: drive after the edge, then predict and check on the falling edge
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] l, input logic r);
    int sel;
    bit has, space, acc;
    @(posedge clk_i);
    #1;
    valid_i = v;
    last_i  = l;
    ready_i = r;
    for (int k = 0; k < N; k++) data_i[k*W +: W] = W'($urandom);
    @(negedge clk_i);
    space = !full || r;
    sel = owner;
    has = owner >= 0;
    if (!has)
      for (int j = N - 1; j >= 0; j--)
        if (v[(ptr + j) % N]) begin
          sel = (ptr + j) % N;
          has = 1;
        end
    acc = space && has && v[sel];
    chk("valid_o", 32'(valid_o), 32'(full));
    chk("ready_o", 32'(ready_o), (space && has) ? 32'(1) << sel : 0);
    if (acc) begin
      sb.push_back({l[sel], 2'(sel), data_i[sel*W +: W]});
      if (l[sel]) begin
        owner = -1;
        ptr = (sel + 1) % N;
      end else owner = sel;
    end
    full = acc ? 1'b1 : (r ? 1'b0 : full);
  endtask
  logic [W-1:0] prev_data;
  bit stalled = 0;
  always @(negedge clk_i) begin
    logic [W+2:0] e;
    if (!reset_i) stalled = 0;
    else if (valid_o) begin
      if (stalled) chk("stable_data", 32'(data_r_o), 32'(prev_data));
      if (ready_i) begin
        if (sb.size() == 0) chk("unexpected_beat", 32'(1), 32'(0));
        else begin
          e = sb.pop_front();
          chk("data_r_o", 32'(data_r_o), 32'(e[W-1:0]));
          chk("id_r_o", 32'(id_r_o), 32'(e[W+1:W]));
          chk("last_r_o", 32'(last_r_o), 32'(e[W+2]));
        end
      end
      stalled = !ready_i;
      prev_data = data_r_o;
    end else stalled = 0;
  end
  initial begin
    valid_i = 4'b1111;
    last_i  = 4'b1111;
    #1 reset_i = 1'b0;
    #2;
    chk("rst_valid_o", 32'(valid_o), 0);
    chk("rst_ready_o", 32'(ready_o), 0);
    chk("rst_data", 32'(data_r_o), 0);
    chk("rst_id", 32'(id_r_o), 0);
    chk("rst_last", 32'(last_r_o), 0);
    valid_i = '0;
    last_i  = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b1;
    repeat (5) step(4'b1111, 4'b1111, 1'b1);
    step(4'b0110, 4'b0000, 1'b1);
    step(4'b0110, 4'b0000, 1'b1);
    step(4'b0110, 4'b0010, 1'b1);
    step(4'b0100, 4'b0100, 1'b1);
    repeat (6) step(4'b1111, 4'b1111, 1'b0);
    repeat (2) step(4'b1111, 4'b1111, 1'b1);
    step(4'b1000, 4'b0000, 1'b1);
    repeat (2) step(4'b0001, 4'b0000, 1'b1);
    step(4'b1001, 4'b1000, 1'b1);
    step(4'b0001, 4'b0001, 1'b1);
    step(4'b0100, 4'b0100, 1'b1);
    repeat (2) step(4'b1001, 4'b1001, 1'b1);
    repeat (2) step(4'b0010, 4'b0000, 1'b1);
    #2 reset_i = 1'b0;
    #1;
    chk("async_rst_valid_o", 32'(valid_o), 0);
    chk("async_rst_ready_o", 32'(ready_o), 0);
    chk("async_rst_data", 32'(data_r_o), 0);
    owner = -1;
    ptr = 0;
    full = 0;
    sb.delete();
    valid_i = '0;
    @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b1;
    repeat (3) step(4'b0100, 4'b0100, 1'b1);
    for (int c = 0; c < 400; c++)
      step(N'($urandom), N'($urandom_range(0, 15) & $urandom_range(0, 15)), $urandom_range(0, 3) != 0);
    repeat (4) step(4'b0000, 4'b0000, 1'b1);
    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
